// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router defaults: payload width, FIFO depth, SOP flag position
package router_pkg;

  localparam int ROUTER_DATA_WIDTH = 8;
  localparam int ROUTER_DEPTH      = 16;

  // The SOP flag rides in the bit just above the payload of each stored entry.
  function automatic int sop_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// rtl/router_fifo_ptr.sv - FIFO pointer register with increment and empty/full compare against a peer pointer
module router_fifo_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  input  logic [PTR_W-1:0] peer_ptr,
  output logic [PTR_W-1:0] ptr,
  output logic             match,
  output logic             lapped
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  // Extra MSB distinguishes a full FIFO (one lap apart) from an empty one.
  assign match  = (ptr == peer_ptr);
  assign lapped = (ptr[PTR_W-1] != peer_ptr[PTR_W-1]) &&
                  (ptr[PTR_W-2:0] == peer_ptr[PTR_W-2:0]);

endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - router output FIFO with SOP-tagged entries and packet-end tracking
// Optional occupancy ports fill_level/almost_full under ROUTER_PKT_FIFO_FILL_LEVEL_EN.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int DEPTH      = ROUTER_DEPTH,
  parameter int LEN_LSB    = 2,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
`ifdef ROUTER_PKT_FIFO_FILL_LEVEL_EN
  output logic                  pkt_done,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                  almost_full
`else
  output logic                  pkt_done
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = DATA_WIDTH - LEN_LSB + 1;
  localparam int SOP   = sop_bit(DATA_WIDTH);

  if (DATA_WIDTH < 4 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      LEN_LSB >= DATA_WIDTH || AF_MARGIN > DEPTH) begin : g_bad_cfg
    $error("router_pkt_fifo: unsupported parameter set");
  end

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   wr_entry;
  logic [DATA_WIDTH:0]   rd_entry;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_match, rd_match, wr_lapped, rd_lapped;
  logic                  wr_acc, rd_acc;
  logic                  rd_sop;
  logic [CNT_W-2:0]      rd_len;
  logic [CNT_W-1:0]      pkt_cnt;

  // The compare is symmetric, so either instance's view gives the same answer.
  assign empty  = wr_match & rd_match;
  assign full   = wr_lapped & rd_lapped;
  assign wr_acc = write_enb && !full && !soft_reset;
  assign rd_acc = read_enb && !empty && !soft_reset;

  router_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (soft_reset),
    .inc      (wr_acc),
    .peer_ptr (rd_ptr),
    .ptr      (wr_ptr),
    .match    (wr_match),
    .lapped   (wr_lapped)
  );

  router_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (soft_reset),
    .inc      (rd_acc),
    .peer_ptr (wr_ptr),
    .ptr      (rd_ptr),
    .match    (rd_match),
    .lapped   (rd_lapped)
  );

  always_comb begin
    wr_entry                   = '0;
    wr_entry[DATA_WIDTH-1:0]   = data_in;
    wr_entry[SOP]              = lfd_state;
  end

  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign rd_sop   = rd_entry[SOP];
  assign rd_len   = rd_entry[DATA_WIDTH-1:LEN_LSB];

  // Header loads length+1 so the parity byte closes the packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
    end else if (soft_reset) begin
      pkt_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      pkt_done   <= 1'b0;
      if (rd_acc) begin
        data_out <= rd_entry[DATA_WIDTH-1:0];
        if (rd_sop) begin
          pkt_cnt <= {1'b0, rd_len} + CNT_W'(1);
        end else if (pkt_cnt != '0) begin
          pkt_cnt  <= pkt_cnt - CNT_W'(1);
          pkt_done <= (pkt_cnt == CNT_W'(1));
        end
      end
    end
  end

`ifdef ROUTER_PKT_FIFO_FILL_LEVEL_EN
  assign fill_level  = wr_ptr - rd_ptr;
  assign almost_full = (fill_level >= PTR_W'(DEPTH - AF_MARGIN));
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed and randomized checks of router_pkt_fifo against a queue model
module tb_router_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          resetn;
  logic          soft_reset;
  logic          write_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic          read_enb;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          empty;
  logic          full;
  logic          pkt_done;
`ifdef ROUTER_PKT_FIFO_FILL_LEVEL_EN
  logic [4:0]    fill_level;
  logic          almost_full;
`endif

  always #5 clock = ~clock;

  router_pkt_fifo dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .read_enb    (read_enb),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
`ifdef ROUTER_PKT_FIFO_FILL_LEVEL_EN
    .pkt_done    (pkt_done),
    .fill_level  (fill_level),
    .almost_full (almost_full)
`else
    .pkt_done    (pkt_done)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue, plus the bytes left in the current packet.
  logic [DW:0]   q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_done;
  int            m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".empty"}, empty, (q.size() == 0));
    chk({tag, ".full"}, full, (q.size() == DEPTH));
`ifdef ROUTER_PKT_FIFO_FILL_LEVEL_EN
    chk({tag, ".fill_level"}, fill_level, q.size());
    chk({tag, ".almost_full"}, almost_full, (q.size() >= DEPTH - 2));
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data_valid"}, data_valid, m_valid);
    chk({tag, ".pkt_done"}, pkt_done, m_done);
    chk({tag, ".data_out"}, data_out, m_dout);
    chk({tag, ".pkt_cnt"}, dut.pkt_cnt, m_cnt);
  endtask

  // One clock: drive, check combinational status, clock, update the model, check registered outputs.
  task automatic cycle(input string tag, input logic we, input logic sop,
                       input logic [DW-1:0] din, input logic re);
    bit          wa, ra;
    logic [DW:0] e;
    write_enb  = we;
    lfd_state  = sop;
    data_in    = din;
    read_enb   = re;
    soft_reset = 1'b0;
    #1;
    check_status(tag);
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() != 0);
    @(posedge clock);
    #1;
    m_done = 1'b0;
    if (ra) begin
      e       = q.pop_front();
      m_dout  = e[DW-1:0];
      m_valid = 1'b1;
      if (e[DW]) begin
        m_cnt = int'(e[DW-1:2]) + 1;
      end else if (m_cnt > 0) begin
        m_cnt  = m_cnt - 1;
        m_done = (m_cnt == 0);
      end
    end else begin
      m_valid = 1'b0;
    end
    if (wa) q.push_back({sop, din});
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
    check_outputs(tag);
  endtask

  function automatic logic [DW-1:0] rnd_byte();
    return DW'($urandom_range(1, 255));
  endfunction

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    read_enb   = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_status("reset");
    check_outputs("reset");
    resetn = 1'b1;

    // Header 0x14 carries length 5: five payload bytes plus parity, closed by the 7th read.
    cycle("pkt_hdr", 1'b1, 1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 6; i++) cycle("pkt_wr", 1'b1, 1'b0, rnd_byte(), 1'b0);
    for (int i = 0; i < 6; i++) cycle("pkt_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    cycle("pkt_last", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("pkt_done_7th", pkt_done, 1'b1);
    chk("pkt_cnt_zero", dut.pkt_cnt, 0);

    // Fill to full, try an overflow write, drain in order, then an underflow read.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'($urandom_range(0, 8'hA9)), 1'b0);
    chk("full_at_16", full, 1'b1);
    cycle("overflow", 1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle("drain", 1'b0, 1'b0, 8'h00, 1'b1);
      assert (data_out !== 8'hAA) else begin
        errors++;
        $error("FAIL drain_no_aa observed=%0h expected=not_aa", data_out);
      end
      checks++;
    end
    chk("empty_after_drain", empty, 1'b1);
    cycle("underflow", 1'b0, 1'b0, 8'h00, 1'b1);

    // 40 write/read pairs wrap both pointers; random headers exercise the counter.
    for (int i = 0; i < 40; i++) begin
      cycle("wrap_wr", 1'b1, ($urandom_range(0, 3) == 0), DW'($urandom), 1'b0);
      cycle("wrap_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Simultaneous read and write at occupancy 8.
    for (int i = 0; i < 8; i++) cycle("occ8_fill", 1'b1, 1'b0, rnd_byte(), 1'b0);
    for (int i = 0; i < 4; i++) cycle("occ8_rw", 1'b1, 1'b0, rnd_byte(), 1'b1);
    chk("occ8_depth", dut.wr_ptr - dut.rd_ptr, 5'(q.size()));
    chk("occ8_model", q.size(), 8);

    // Soft reset beats a simultaneous read and write at occupancy 5.
    for (int i = 0; i < 3; i++) cycle("occ5_drain", 1'b0, 1'b0, 8'h00, 1'b1);
    write_enb  = 1'b1;
    read_enb   = 1'b1;
    data_in    = 8'h5C;
    soft_reset = 1'b1;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    model_clear();
    chk("soft_empty", empty, 1'b1);
    chk("soft_valid", data_valid, 1'b0);
    chk("soft_dout", data_out, 8'h00);
    check_outputs("soft_reset");
    cycle("soft_after", 1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-packet, with three bytes still owed.
    cycle("mid_hdr", 1'b1, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 5; i++) cycle("mid_wr", 1'b1, 1'b0, rnd_byte(), 1'b0);
    for (int i = 0; i < 3; i++) cycle("mid_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_cnt3", dut.pkt_cnt, 3);
    #1;
    resetn = 1'b0;
    #1;
    model_clear();
    check_status("async_rst");
    check_outputs("async_rst");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cycle("new_hdr", 1'b1, 1'b1, 8'h08, 1'b0);
    for (int i = 0; i < 3; i++) cycle("new_wr", 1'b1, 1'b0, rnd_byte(), 1'b0);
    cycle("new_rd_hdr", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("new_first_is_hdr", data_out, 8'h08);
    for (int i = 0; i < 3; i++) cycle("new_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("new_pkt_done", pkt_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload byte width (>=4).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=4).
REQ-003 SHALL have parameter LEN_LSB, default 2, lowest header bit of the length field [DATA_WIDTH-1:LEN_LSB].
REQ-004 SHALL have parameter AF_MARGIN, default 2, almost_full threshold distance from full.
REQ-005 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port soft_reset  in  1  synchronous flush (router timeout).
REQ-008 SHALL have port write_enb  in  1  write request.
REQ-009 SHALL have port lfd_state  in  1  marks data_in as packet header (SOP).
REQ-010 SHALL have port data_in  in  DATA_WIDTH  write data.
REQ-011 SHALL have port read_enb  in  1  read request.
REQ-012 SHALL have port data_out  out  DATA_WIDTH  registered read data.
REQ-013 SHALL have port data_valid  out  1  data_out updated this cycle.
REQ-014 SHALL have port empty  out  1, and port full  out  1, combinational pointer status.
REQ-015 SHALL have port pkt_done  out  1  one-cycle pulse with the last byte of a packet on data_out.
REQ-016 SHALL have ports fill_level  out  $clog2(DEPTH)+1, and almost_full  out  1, present only per REQ-032.

Function
REQ-017 SHALL store DATA_WIDTH+1 bits per entry: {lfd_state, data_in}.
REQ-018 SHALL accept a write when write_enb && !full; a write while full is dropped, pointers unchanged.
REQ-019 SHALL accept a read when read_enb && !empty; a read while empty is ignored, data_valid stays 0.
REQ-020 SHALL allow a simultaneous accepted read and write in one cycle; occupancy unchanged.
REQ-021 SHALL use $clog2(DEPTH)+1-bit pointers; empty = all bits equal, full = MSB differs and rest equal; wrap-around is natural overflow.
REQ-022 SHALL register read data: data_out and data_valid=1 appear the cycle after an accepted read (1-cycle latency); data_out holds otherwise, data_valid=0.
REQ-023 SHALL track packet bytes with counter (width DATA_WIDTH-LEN_LSB+1): reading an SOP entry loads length+1 (payload plus parity), reading a non-SOP entry decrements.
REQ-024 SHALL saturate counter at 0 (non-SOP read with counter 0 leaves it 0, no pkt_done).
REQ-025 SHALL pulse pkt_done together with data_valid when a read drives counter 1->0.
REQ-026 SHALL give soft_reset priority over read and write in the same cycle: pointers, counter, data_out, data_valid, pkt_done to 0.

Reset
REQ-027 SHALL on resetn low immediately clear pointers, counter, data_out, data_valid, pkt_done (empty=1, full=0).
REQ-028 SHALL not reset memory contents; the array holds no reset logic.
REQ-029 SHALL discard any packet in flight on reset mid-operation; the first read after release is from the entry written first after reset.

Configuration
REQ-030 SHALL compile occupancy status under macro ROUTER_PKT_FIFO_FILL_LEVEL_EN.
REQ-031 SHALL with the macro: fill_level = write_ptr - read_ptr (0..DEPTH), almost_full = fill_level >= DEPTH-AF_MARGIN, both combinational.
REQ-032 SHALL without the macro: omit fill_level and almost_full ports and their logic entirely.

Structure
REQ-033 SHALL take the default DATA_WIDTH, DEPTH, and the SOP-flag bit position from shared package router_pkg.
REQ-034 SHALL instantiate one sub-module router_fifo_ptr (pointer register, increment, empty/full compare), used twice... once for write and once for read pointer; memory and counter stay in the top.

Verification
REQ-035 SHALL cover: reset, write header 0x14 (length 5) + 6 bytes, read 7 -> pkt_done with 7th data_valid, counter 0.
REQ-036 SHALL cover: 16 writes -> full=1; 17th write 0xAA dropped; 16 reads return written order, no 0xAA, then empty=1.
REQ-037 SHALL cover: 40 write/read pairs over 16-entry FIFO -> pointer wrap, data order intact, empty/full never falsely set.
REQ-038 SHALL cover: simultaneous read and write at occupancy 8 -> occupancy stays 8 (fill_level=8 with macro).
REQ-039 SHALL cover: soft_reset asserted with write_enb and read_enb at occupancy 5 -> next cycle empty=1, data_valid=0, data_out=0.
REQ-040 SHALL cover: resetn dropped mid-packet (counter 3) -> outputs 0 asynchronously; new packet afterwards counts from its own header.
